// File: rtl/key_debounce_multi.sv
// rtl/key_debounce_multi.sv - multi-channel key debouncer with press/release/long/repeat pulses
// Each channel: 2-FF synchronizer, debounce filter FSM, hold counter for long-press and auto-repeat.
module key_debounce_multi #(
  parameter int N_KEYS       = 4,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int DEBOUNCE_CYC = 480000,
  parameter int LONG_CYC     = 24000000,
  parameter int REPEAT_CYC   = 4800000,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_KEYS-1:0] KEY_IN,
  output logic [N_KEYS-1:0] KEY_STATE,
  output logic [N_KEYS-1:0] KEY_PRESS,
  output logic [N_KEYS-1:0] KEY_RELEASE,
  output logic [N_KEYS-1:0] KEY_LONG,
  output logic [N_KEYS-1:0] KEY_REPEAT,
  output logic              KEY_ANY
);

  localparam int HOLD_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int DB_W     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYC - 1);
  localparam logic              PRESSED_LVL = ACTIVE_LOW ? 1'b0 : 1'b1;

  typedef enum logic [1:0] {
    ST_UP      = 2'd0,
    ST_FILT_DN = 2'd1,
    ST_DOWN    = 2'd2,
    ST_FILT_UP = 2'd3
  } state_e;

  logic [N_KEYS-1:0] press_vec_d;
  logic              key_any_q, key_any_d;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    state_e            state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_done_q, long_done_d;
    logic              key_state_q, key_state_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;
    logic              p;

    assign p = (sync2_q == PRESSED_LVL);

    always_comb begin
      sync1_d     = KEY_IN[i];
      sync2_d     = sync1_q;
      state_d     = state_q;
      db_cnt_d    = db_cnt_q;
      hold_d      = hold_q;
      long_done_d = long_done_q;
      key_state_d = key_state_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
      repeat_d    = 1'b0;
      case (state_q)
        ST_UP: begin
          db_cnt_d = '0;
          if (p) state_d = ST_FILT_DN;
        end
        ST_FILT_DN: begin
          if (!p) begin
            state_d  = ST_UP;
            db_cnt_d = '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_d     = ST_DOWN;
            press_d     = 1'b1;
            key_state_d = 1'b0;
            hold_d      = '0;
            long_done_d = 1'b0;
            db_cnt_d    = '0;
          end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
          end
        end
        ST_DOWN: begin
          if (!p) begin
            state_d  = ST_FILT_UP;
            db_cnt_d = '0;
          end else if (!long_done_q && hold_q == LONG_LAST) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
            hold_d      = '0;
          end else if (long_done_q && REPEAT_EN && hold_q == REPEAT_LAST) begin
            repeat_d = 1'b1;
            hold_d   = '0;
          end else if (!(long_done_q && !REPEAT_EN)) begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        ST_FILT_UP: begin
          // Hold count and long_done survive a short release bounce.
          if (p) begin
            state_d = ST_DOWN;
          end else if (db_cnt_q == DB_LAST) begin
            state_d     = ST_UP;
            release_d   = 1'b1;
            key_state_d = 1'b1;
            db_cnt_d    = '0;
          end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
          end
        end
        default: begin
          state_d     = ST_UP;
          key_state_d = 1'b1;
          db_cnt_d    = '0;
        end
      endcase
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        sync1_q     <= ~PRESSED_LVL;
        sync2_q     <= ~PRESSED_LVL;
        state_q     <= ST_UP;
        db_cnt_q    <= '0;
        hold_q      <= '0;
        long_done_q <= 1'b0;
        key_state_q <= 1'b1;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        long_q      <= 1'b0;
        repeat_q    <= 1'b0;
      end else begin
        sync1_q     <= sync1_d;
        sync2_q     <= sync2_d;
        state_q     <= state_d;
        db_cnt_q    <= db_cnt_d;
        hold_q      <= hold_d;
        long_done_q <= long_done_d;
        key_state_q <= key_state_d;
        press_q     <= press_d;
        release_q   <= release_d;
        long_q      <= long_d;
        repeat_q    <= repeat_d;
      end
    end

    assign press_vec_d[i] = press_d;
    assign KEY_STATE[i]   = key_state_q;
    assign KEY_PRESS[i]   = press_q;
    assign KEY_RELEASE[i] = release_q;
    assign KEY_LONG[i]    = long_q;
    assign KEY_REPEAT[i]  = repeat_q;
  end

  always_comb begin
    key_any_d = |press_vec_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) key_any_q <= 1'b0;
    else     key_any_q <= key_any_d;
  end

  assign KEY_ANY = key_any_q;

endmodule
